// File: rtl/env_pkg.sv
// Shared definitions for the ADSR envelope generator: phase encoding and code constants.
package env_pkg;

    localparam int ENV_STATE_W = 3;

    typedef enum logic [ENV_STATE_W-1:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam logic [ENV_STATE_W-1:0] CODE_IDLE    = 3'd0;
    localparam logic [ENV_STATE_W-1:0] CODE_ATTACK  = 3'd1;
    localparam logic [ENV_STATE_W-1:0] CODE_DECAY   = 3'd2;
    localparam logic [ENV_STATE_W-1:0] CODE_SUSTAIN = 3'd3;
    localparam logic [ENV_STATE_W-1:0] CODE_RELEASE = 3'd4;

endpackage

// File: rtl/env_step.sv
// One envelope step: add or subtract an amount from the current value, clamped at a target,
// flagging when the target is reached. A zero amount jumps straight to the target.
module env_step #(
    parameter int C_WIDTH = 32
) (
    input  logic [C_WIDTH-1:0] value,
    input  logic [C_WIDTH:0]   amount,
    input  logic [C_WIDTH-1:0] target,
    input  logic               subtract,
    output logic [C_WIDTH-1:0] result,
    output logic               reached
);

    logic [C_WIDTH:0] wide_value;
    logic [C_WIDTH:0] wide_target;
    logic [C_WIDTH:0] sum;
    logic [C_WIDTH:0] diff;

    assign wide_value  = {1'b0, value};
    assign wide_target = {1'b0, target};
    assign sum         = wide_value + amount;
    assign diff        = wide_value - amount;

    // The extra top bit keeps sums from wrapping; underflow is ruled out before diff is trusted.
    always_comb begin
        result  = target;
        reached = 1'b1;
        if (amount != '0) begin
            if (subtract) begin
                if ((amount < wide_value) && (diff > wide_target)) begin
                    result  = diff[C_WIDTH-1:0];
                    reached = 1'b0;
                end
            end else if (sum < wide_target) begin
                result  = sum[C_WIDTH-1:0];
                reached = 1'b0;
            end
        end
    end

endmodule

// File: rtl/envelope_gen.sv
// ADSR envelope generator stepped by a sample tick; env feeds a downstream multiplier.
// Define ENV_EXP_RELEASE_EN for an exponential release ((env >> rate[4:0]) + 1 per tick).
module envelope_gen
    import env_pkg::*;
#(
    parameter int                 C_WIDTH = 32,
    parameter logic [C_WIDTH-1:0] ENV_MAX = {C_WIDTH{1'b1}}
) (
    input  logic                   ctl_clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   gate,
    input  logic [C_WIDTH-1:0]     attack_rate,
    input  logic [C_WIDTH-1:0]     decay_rate,
    input  logic [C_WIDTH-1:0]     sustain_level,
    input  logic [C_WIDTH-1:0]     release_rate,
    output logic [C_WIDTH-1:0]     env,
    output logic                   env_valid,
    output logic [ENV_STATE_W-1:0] state,
    output logic                   busy
);

    env_state_t         phase;
    env_state_t         phase_next;
    logic [C_WIDTH-1:0] env_next;
    logic               gate_q;
    logic               rise;
    logic               fall;

    logic [C_WIDTH:0]   release_step;
    logic [C_WIDTH:0]   step_amount;
    logic [C_WIDTH-1:0] step_target;
    logic               step_sub;
    logic [C_WIDTH-1:0] step_result;
    logic               step_reached;

    assign rise = gate & ~gate_q;
    assign fall = ~gate & gate_q;

`ifdef ENV_EXP_RELEASE_EN
    assign release_step = {1'b0, env >> release_rate[4:0]} + {{C_WIDTH{1'b0}}, 1'b1};
`else
    assign release_step = {1'b0, release_rate};
`endif

    assign step_amount = (phase == ATTACK) ? {1'b0, attack_rate} :
                         (phase == DECAY)  ? {1'b0, decay_rate}  : release_step;
    assign step_target = (phase == ATTACK) ? ENV_MAX :
                         (phase == DECAY)  ? sustain_level : '0;
    assign step_sub    = (phase != ATTACK);

    env_step #(
        .C_WIDTH (C_WIDTH)
    ) u_step (
        .value    (env),
        .amount   (step_amount),
        .target   (step_target),
        .subtract (step_sub),
        .result   (step_result),
        .reached  (step_reached)
    );

    always_ff @(posedge ctl_clk or negedge reset) begin
        if (!reset) begin
            phase     <= IDLE;
            env       <= '0;
            gate_q    <= 1'b0;
            env_valid <= 1'b0;
        end else begin
            env_valid <= tick;
            if (tick) begin
                phase  <= phase_next;
                env    <= env_next;
                gate_q <= gate;
            end
        end
    end

    // Gate edges only redirect the phase; the new phase's step starts on the following tick.
    always_comb begin
        phase_next = phase;
        env_next   = env;
        case (phase)
            IDLE: begin
                env_next = '0;
                if (rise) phase_next = ATTACK;
            end
            ATTACK, DECAY: begin
                if (rise) begin
                    phase_next = ATTACK;
                end else if (fall) begin
                    phase_next = RELEASE;
                end else begin
                    env_next = step_result;
                    if (step_reached) phase_next = (phase == ATTACK) ? DECAY : SUSTAIN;
                end
            end
            SUSTAIN: begin
                if (rise) begin
                    phase_next = ATTACK;
                end else if (fall) begin
                    phase_next = RELEASE;
                end else begin
                    env_next = sustain_level;
                end
            end
            RELEASE: begin
                if (rise) begin
                    phase_next = ATTACK;
                end else begin
                    env_next = step_result;
                    if (step_reached) phase_next = IDLE;
                end
            end
            default: begin
                phase_next = IDLE;
                env_next   = '0;
            end
        endcase
    end

    always_comb begin
        state = phase;
        busy  = (phase != IDLE);
    end

endmodule
